// File: rtl/sram_array_seq.sv
`timescale 1ns/1ps
// Request/response sequencer for the compiled SRAM macro: turns single-beat reads and
// writes into timed write_en / active-low sense_en strobes, with optional write-verify.
module sram_array_seq #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 11,
  parameter int DEPTH          = 2048,
  parameter int WR_CYCLES      = 2,
  parameter int SENSE_CYCLES   = 1,
  parameter int RECOVER_CYCLES = 1,
  parameter int VERIFY         = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              err_sticky,
  output logic [ADDR_W-1:0] err_addr,
  input  logic              err_clr,
  output logic              write_en,
  output logic              sense_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] dout
);

  localparam int MAX_WS = (WR_CYCLES > SENSE_CYCLES) ? WR_CYCLES : SENSE_CYCLES;
  localparam int MAX_PH = (MAX_WS > RECOVER_CYCLES) ? MAX_WS : RECOVER_CYCLES;
  localparam int CNT_W  = $clog2(MAX_PH) + 1;

  // Counter is loaded with length-1 and the phase ends on the cycle it reads zero.
  localparam logic [CNT_W-1:0] WR_LOAD    = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] SENSE_LOAD = CNT_W'(SENSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECOV_LOAD = CNT_W'(RECOVER_CYCLES - 1);
  localparam logic [ADDR_W:0]  DEPTH_LIM  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, WRITE, GAP, SENSE, RESP, RECOV} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             verify_reg;
  logic             skip_recov_reg;
  logic             in_range;

  assign in_range = ({1'b0, req_addr} < DEPTH_LIM);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      verify_reg     <= 1'b0;
      skip_recov_reg <= 1'b0;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      err_sticky     <= 1'b0;
      err_addr       <= '0;
      write_en       <= 1'b0;
      sense_en       <= 1'b1;
      addr           <= '0;
      din            <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready      <= 1'b0;
            addr           <= req_addr;
            din            <= req_wdata;
            skip_recov_reg <= !in_range;
            verify_reg     <= req_we && (VERIFY != 0);
            if (!in_range) begin
              // Rejected addresses never touch the array and skip recovery.
              state_reg <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
            end else if (req_we) begin
              state_reg <= WRITE;
              write_en  <= 1'b1;
              cnt_reg   <= WR_LOAD;
            end else begin
              state_reg <= SENSE;
              sense_en  <= 1'b0;
              cnt_reg   <= SENSE_LOAD;
            end
          end
        end
        WRITE: begin
          if (cnt_reg == '0) begin
            write_en <= 1'b0;
            if (verify_reg) begin
              state_reg <= GAP;
              cnt_reg   <= RECOV_LOAD;
            end else begin
              state_reg <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_reg == '0) begin
            state_reg <= SENSE;
            sense_en  <= 1'b0;
            cnt_reg   <= SENSE_LOAD;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        SENSE: begin
          if (cnt_reg == '0) begin
            state_reg <= RESP;
            sense_en  <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= dout;
            rsp_err   <= verify_reg && (dout != din);
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          if (skip_recov_reg) begin
            state_reg <= IDLE;
            req_ready <= 1'b1;
          end else begin
            state_reg <= RECOV;
            cnt_reg   <= RECOV_LOAD;
          end
        end
        RECOV: begin
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
            req_ready <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          req_ready <= 1'b1;
          write_en  <= 1'b0;
          sense_en  <= 1'b1;
        end
      endcase

      // A clear in the same cycle as a new error makes that error the first one.
      if (state_reg == RESP && rsp_err) begin
        err_sticky <= 1'b1;
        if (!err_sticky || err_clr) err_addr <= addr;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
        err_addr   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sram_array_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for sram_array_seq: instance 0 uses defaults, instance 1 VERIFY=1 with
// DEPTH=1536 and a stuck-at-0 bit 3 at 0x010/0x020, instance 2 slow timing with 16-bit data.
module tb_sram_array_seq;

  typedef struct {
    int          inst;
    logic [15:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  logic [2:0]  req_valid = '0;
  logic [2:0]  req_we = '0;
  logic [2:0]  err_clr = '0;
  logic [10:0] req_addr [3];
  logic [15:0] req_wdata [3];
  wire  [2:0]  req_ready, rsp_valid, rsp_err, err_sticky, write_en, sense_en;

  wire [7:0]  rsp_rdata0, rsp_rdata1, din0, din1;
  wire [15:0] rsp_rdata2, din2;
  wire [10:0] err_addr0, err_addr1, err_addr2, addr0, addr1, addr2;
  wire [7:0]  dout0, dout1;
  wire [15:0] dout2;

  logic [15:0] rdata_v [3];
  logic [10:0] err_addr_v [3];
  logic [10:0] addr_v [3];
  logic [15:0] din_v [3];
  assign rdata_v[0] = {8'h00, rsp_rdata0};
  assign rdata_v[1] = {8'h00, rsp_rdata1};
  assign rdata_v[2] = rsp_rdata2;
  assign err_addr_v[0] = err_addr0;
  assign err_addr_v[1] = err_addr1;
  assign err_addr_v[2] = err_addr2;
  assign addr_v[0] = addr0;
  assign addr_v[1] = addr1;
  assign addr_v[2] = addr2;
  assign din_v[0] = {8'h00, din0};
  assign din_v[1] = {8'h00, din1};
  assign din_v[2] = din2;

  // Attached array models; instance 1 has bit 3 stuck at 0 on two words.
  logic [15:0] arr [3][2048];
  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (write_en[i]) arr[i][addr_v[i]] <= din_v[i];
  assign dout0 = sense_en[0] ? 8'h00 : arr[0][addr0][7:0];
  assign dout1 = sense_en[1] ? 8'h00 :
                 (arr[1][addr1][7:0] & ((addr1 == 11'h010 || addr1 == 11'h020) ? 8'hF7 : 8'hFF));
  assign dout2 = sense_en[2] ? 16'h0000 : arr[2][addr2];

  sram_array_seq u_def (
    .clk(clk), .resetn(resetn), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0][7:0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err[0]),
    .err_sticky(err_sticky[0]), .err_addr(err_addr0), .err_clr(err_clr[0]),
    .write_en(write_en[0]), .sense_en(sense_en[0]), .addr(addr0), .din(din0), .dout(dout0)
  );

  sram_array_seq #(.DEPTH(1536), .VERIFY(1)) u_ver (
    .clk(clk), .resetn(resetn), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1][7:0]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err[1]),
    .err_sticky(err_sticky[1]), .err_addr(err_addr1), .err_clr(err_clr[1]),
    .write_en(write_en[1]), .sense_en(sense_en[1]), .addr(addr1), .din(din1), .dout(dout1)
  );

  sram_array_seq #(.DATA_W(16), .WR_CYCLES(3), .SENSE_CYCLES(2), .RECOVER_CYCLES(2)) u_slow (
    .clk(clk), .resetn(resetn), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err[2]),
    .err_sticky(err_sticky[2]), .err_addr(err_addr2), .err_clr(err_clr[2]),
    .write_en(write_en[2]), .sense_en(sense_en[2]), .addr(addr2), .din(din2), .dout(dout2)
  );

  // Per-instance parameters as the bench sees them.
  function automatic int wr_c(input int i);  return (i == 2) ? 3 : 2; endfunction
  function automatic int sn_c(input int i);  return (i == 2) ? 2 : 1; endfunction
  function automatic int rc_c(input int i);  return (i == 2) ? 2 : 1; endfunction
  function automatic int dep(input int i);   return (i == 1) ? 1536 : 2048; endfunction
  function automatic bit ver(input int i);   return (i == 1); endfunction
  function automatic logic [15:0] dmask(input int i); return (i == 2) ? 16'hFFFF : 16'h00FF; endfunction
  function automatic bit stuck(input int i, input logic [10:0] a);
    return (i == 1) && (a == 11'h010 || a == 11'h020);
  endfunction

  logic [15:0] ref_mem [3][2048];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called at a negedge. Pushes the expected response, then watches the busy window.
  task automatic issue(input int i, input bit we, input logic [10:0] a, input logic [15:0] d,
                       input bit hold, input bit clr_in_resp);
    exp_t x;
    int e, busy, wc, sc, wexp, sexp, n;
    logic [15:0] dm, rb;
    dm = d & dmask(i);
    n = 0;
    while (req_ready[i] !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    if (req_ready[i] !== 1'b1) begin
      chk($sformatf("ready_timeout[%0d]", i), 32'(req_ready[i]), 1);
      return;
    end
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_wdata[i] = dm;
    e = cyc + 1;
    x.inst = i; x.rdata = '0; x.err = 1'b0;
    if (int'(a) >= dep(i)) begin
      x.err = 1'b1; x.cyc = e; busy = 1; wexp = 0; sexp = 0;
    end else if (we) begin
      ref_mem[i][a] = dm;
      wexp = wr_c(i);
      if (ver(i)) begin
        rb = stuck(i, a) ? (dm & 16'hFFF7) : dm;
        x.rdata = rb; x.err = (rb != dm); sexp = sn_c(i);
        x.cyc = e + wr_c(i) + rc_c(i) + sn_c(i);
        busy = wr_c(i) + rc_c(i) + sn_c(i) + 1 + rc_c(i);
      end else begin
        sexp = 0; x.cyc = e + wr_c(i); busy = wr_c(i) + 1 + rc_c(i);
      end
    end else begin
      rb = ref_mem[i][a];
      x.rdata = stuck(i, a) ? (rb & 16'hFFF7) : rb;
      wexp = 0; sexp = sn_c(i); x.cyc = e + sn_c(i); busy = sn_c(i) + 1 + rc_c(i);
    end
    exp_q.push_back(x);
    @(negedge clk);
    wc = 0; sc = 0; n = 0;
    while (req_ready[i] !== 1'b1 && n < 64) begin
      if (hold) begin
        req_we[i] = 1'($urandom); req_addr[i] = 11'($urandom);
        req_wdata[i] = 16'($urandom) & dmask(i);
      end else begin
        req_valid[i] = 1'b0;
      end
      err_clr[i] = clr_in_resp && (n == 0);
      wc += int'(write_en[i]);
      sc += int'(!sense_en[i]);
      @(negedge clk); n++;
    end
    err_clr[i] = 1'b0;
    if (!hold) req_valid[i] = 1'b0;
    chk($sformatf("ready_return[%0d] a=%0h", i, a), cyc, e + busy);
    chk($sformatf("write_en_cycles[%0d] a=%0h", i, a), wc, wexp);
    chk($sformatf("sense_low_cycles[%0d] a=%0h", i, a), sc, sexp);
  endtask

  // Monitor: pops the scoreboard whenever any instance presents a response.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("strobe_overlap[%0d]", i), 32'(write_en[i] & ~sense_en[i]), 0);
        if (rsp_valid[i]) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("unexpected_rsp[%0d]", i), 32'(rsp_valid[i]), 0);
          end else begin
            x = exp_q.pop_front();
            chk($sformatf("rsp_inst[%0d]", i), i, x.inst);
            chk($sformatf("rsp_rdata[%0d]", i), 32'(rdata_v[i]), 32'(x.rdata));
            chk($sformatf("rsp_err[%0d]", i), 32'(rsp_err[i]), 32'(x.err));
            chk($sformatf("rsp_cycle[%0d]", i), cyc, x.cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] wr_list[$];
    logic [10:0] a, sa [4];
    logic [15:0] sd [4];
    bit          we;
    for (int i = 0; i < 3; i++) begin req_addr[i] = '0; req_wdata[i] = '0; end

    // Reset values, held in reset and after release.
    #3 resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_write_en", 32'(write_en[0]), 0);
    chk("rst_sense_en", 32'(sense_en[0]), 1);
    chk("rst_addr", 32'(addr0), 0);
    chk("rst_din", 32'(din0), 0);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata0), 0);
    chk("rst_rsp_err", 32'(rsp_err[0]), 0);
    chk("rst_err_sticky", 32'(err_sticky[0]), 0);
    chk("rst_err_addr", 32'(err_addr0), 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(req_ready), 32'h7);

    // Defaults: directed write/read, then 100 back-to-back random requests.
    issue(0, 1'b1, 11'h2A5, 16'h005C, 1'b0, 1'b0);
    wr_list.push_back(11'h2A5);
    issue(0, 1'b0, 11'h2A5, 16'h0000, 1'b0, 1'b0);
    for (int n = 0; n < 100; n++) begin
      we = (wr_list.size() == 0) || ($urandom_range(0, 1) == 1);
      if (we) begin
        a = 11'($urandom);
        wr_list.push_back(a);
      end else begin
        a = wr_list[$urandom_range(0, wr_list.size() - 1)];
      end
      issue(0, we, a, 16'($urandom), n < 99, 1'b0);
    end

    // Write-verify, stuck bit, error capture and clear, out-of-range.
    issue(1, 1'b1, 11'h010, 16'h0008, 1'b0, 1'b0);
    chk("sticky_first", 32'(err_sticky[1]), 1);
    chk("err_addr_first", 32'(err_addr1), 32'h010);
    issue(1, 1'b1, 11'h020, 16'h000F, 1'b0, 1'b0);
    chk("sticky_second", 32'(err_sticky[1]), 1);
    chk("err_addr_kept", 32'(err_addr1), 32'h010);
    issue(1, 1'b1, 11'h5FF, 16'h00A5, 1'b0, 1'b0);
    issue(1, 1'b0, 11'h5FF, 16'h0000, 1'b0, 1'b0);
    err_clr[1] = 1'b1;
    @(negedge clk);
    err_clr[1] = 1'b0;
    chk("sticky_cleared", 32'(err_sticky[1]), 0);
    chk("err_addr_cleared", 32'(err_addr1), 0);
    issue(1, 1'b1, 11'h020, 16'h00FF, 1'b0, 1'b0);
    chk("err_addr_after_clear", 32'(err_addr1), 32'h020);
    issue(1, 1'b0, 11'h600, 16'h0000, 1'b0, 1'b1);
    chk("sticky_clr_vs_new", 32'(err_sticky[1]), 1);
    chk("err_addr_clr_vs_new", 32'(err_addr1), 32'h600);
    issue(1, 1'b0, 11'h010, 16'h0000, 1'b0, 1'b0);

    // Slow timing with 16-bit data.
    for (int k = 0; k < 4; k++) begin
      sa[k] = 11'($urandom);
      sd[k] = 16'($urandom);
      issue(2, 1'b1, sa[k], sd[k], 1'b0, 1'b0);
    end
    for (int k = 0; k < 4; k++) issue(2, 1'b0, sa[k], 16'h0000, 1'b0, 1'b0);

    // Reset in the second write_en cycle must drop the strobe without a clock edge.
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 11'h155; req_wdata[0] = 16'h0033;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(posedge clk);
    #2;
    chk("write_en_before_reset", 32'(write_en[0]), 1);
    resetn = 1'b0;
    #1;
    chk("write_en_async_reset", 32'(write_en[0]), 0);
    chk("sense_en_async_reset", 32'(sense_en[0]), 1);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_reset", 32'(req_ready[0]), 1);
    chk("write_en_after_mid_reset", 32'(write_en[0]), 0);

    repeat (4) @(negedge clk);
    chk("pending_responses", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
